// File: rtl/gshare_predictor.sv
// gshare_predictor: tagged BTB + 2-bit-counter PHT, indexed by PC or PC^GHR, with speculative history and EX repair.
// Latency: prediction is combinational from pc_if; table and history updates take effect at the next clk edge.
// Backpressure: none; the fetch side qualifies with if_valid and the resolve side with ex_valid every cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_valid, pc_if     fetch qualifier and fetch PC
//   je, jdest, hist_if  predicted taken, predicted target (0 when not taken), history used for the prediction
//   ex_valid, pc_ex     resolve qualifier and PC of the resolved branch
//   dest, jmp_res       resolved target and actual direction
//   hist_ex, mispred    history carried with the branch, mispredict flag (qualified by ex_valid)
//   ghr                 current speculative global history
module gshare_predictor #(
    parameter int         ADDR_W    = 32,
    parameter int         BTB_IDX_W = 6,
    parameter int         PHT_IDX_W = 8,
    parameter int         HIST_W    = 8,
    parameter bit         GSHARE    = 1'b1,
    parameter logic [1:0] PHT_INIT  = 2'b10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] pc_if,
    output logic              je,
    output logic [ADDR_W-1:0] jdest,
    output logic [HIST_W-1:0] hist_if,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] pc_ex,
    input  logic [ADDR_W-1:0] dest,
    input  logic              jmp_res,
    input  logic [HIST_W-1:0] hist_ex,
    input  logic              mispred,
    output logic [HIST_W-1:0] ghr
);

    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int PHT_N = 1 << PHT_IDX_W;
    localparam int TAG_W = ADDR_W - BTB_IDX_W - 2;

    logic                 btb_valid [BTB_N];
    logic [TAG_W-1:0]     btb_tag   [BTB_N];
    logic [ADDR_W-1:0]    btb_tgt   [BTB_N];
    logic [1:0]           pht       [PHT_N];
    logic [HIST_W-1:0]    ghr_q;

    // PHT index: word-aligned PC bits, optionally folded with the (zero-extended) history.
    function automatic logic [PHT_IDX_W-1:0] pht_index(input logic [ADDR_W-1:0] pc,
                                                       input logic [HIST_W-1:0] hist);
        logic [PHT_IDX_W-1:0] idx;
        idx = pc[PHT_IDX_W+1:2];
        if (GSHARE)
            idx = idx ^ PHT_IDX_W'(hist);
        return idx;
    endfunction

    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic up);
        logic [1:0] nxt;
        nxt = cnt;
        if (up && cnt != 2'b11)
            nxt = cnt + 2'b01;
        else if (!up && cnt != 2'b00)
            nxt = cnt - 2'b01;
        return nxt;
    endfunction

    // Fetch-side lookup
    logic [BTB_IDX_W-1:0] if_bidx;
    logic [TAG_W-1:0]     if_tag;
    logic [PHT_IDX_W-1:0] if_pidx;
    logic                 btb_hit;
    logic                 pred_taken;

    // Resolve-side addressing
    logic [BTB_IDX_W-1:0] ex_bidx;
    logic [TAG_W-1:0]     ex_tag;
    logic [PHT_IDX_W-1:0] ex_pidx;

    // Byte-offset bits never participate in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_if[1:0], pc_ex[1:0]};

    always_comb begin
        if_bidx    = pc_if[BTB_IDX_W+1:2];
        if_tag     = pc_if[ADDR_W-1:BTB_IDX_W+2];
        if_pidx    = pht_index(pc_if, ghr_q);
        btb_hit    = btb_valid[if_bidx] && (btb_tag[if_bidx] == if_tag);
        pred_taken = btb_hit && pht[if_pidx][1];

        ex_bidx    = pc_ex[BTB_IDX_W+1:2];
        ex_tag     = pc_ex[ADDR_W-1:BTB_IDX_W+2];
        // Train the counter the prediction actually used: index with the carried history.
        ex_pidx    = pht_index(pc_ex, hist_ex);
    end

    // Outputs are forced quiet while in reset.
    assign je      = !rst && pred_taken;
    assign jdest   = je ? btb_tgt[if_bidx] : '0;
    assign hist_if = rst ? '0 : ghr_q;
    assign ghr     = ghr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_N; i++)
                btb_valid[i] <= 1'b0;
        end else if (ex_valid) begin
            btb_valid[ex_bidx] <= 1'b1;
        end
    end

    // Tag and target payload carry no reset; the valid bit gates their use.
    always_ff @(posedge clk) begin
        if (!rst && ex_valid) begin
            btb_tag[ex_bidx] <= ex_tag;
            btb_tgt[ex_bidx] <= dest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_N; i++)
                pht[i] <= PHT_INIT;
        end else if (ex_valid) begin
            pht[ex_pidx] <= sat_next(pht[ex_pidx], jmp_res);
        end
    end

    // EX repair wins over the speculative shift; BTB misses leave history untouched.
    always_ff @(posedge clk) begin
        if (rst)
            ghr_q <= '0;
        else if (ex_valid && mispred)
            ghr_q <= {hist_ex[HIST_W-2:0], jmp_res};
        else if (if_valid && btb_hit)
            ghr_q <= {ghr_q[HIST_W-2:0], pred_taken};
    end

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] pc_if;
    logic        ex_valid;
    logic [31:0] pc_ex;
    logic [31:0] dest;
    logic        jmp_res;
    logic [7:0]  hist_ex;
    logic        mispred;

    logic        je_o    [2];
    logic [31:0] jdest_o [2];
    logic [7:0]  hist_o  [2];
    logic [7:0]  ghr_o   [2];

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    always #5 clk = ~clk;

    // Instance 0: bimodal indexing; instance 1: gshare indexing. Same stimulus.
    gshare_predictor #(.GSHARE(1'b0)) u_bim (
        .clk(clk), .rst(rst), .if_valid(if_valid), .pc_if(pc_if),
        .je(je_o[0]), .jdest(jdest_o[0]), .hist_if(hist_o[0]),
        .ex_valid(ex_valid), .pc_ex(pc_ex), .dest(dest), .jmp_res(jmp_res),
        .hist_ex(hist_ex), .mispred(mispred), .ghr(ghr_o[0])
    );

    gshare_predictor #(.GSHARE(1'b1)) u_gsh (
        .clk(clk), .rst(rst), .if_valid(if_valid), .pc_if(pc_if),
        .je(je_o[1]), .jdest(jdest_o[1]), .hist_if(hist_o[1]),
        .ex_valid(ex_valid), .pc_ex(pc_ex), .dest(dest), .jmp_res(jmp_res),
        .hist_ex(hist_ex), .mispred(mispred), .ghr(ghr_o[1])
    );

    // ---------------- behavioural model ----------------
    // BTB remembers the full PC last resolved into each slot; a hit means same slot and same upper address.
    bit          m_valid [2][64];
    logic [31:0] m_pc    [2][64];
    logic [31:0] m_tgt   [2][64];
    int          m_pht   [2][256];
    int          m_ghr   [2];

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic int cidx(input int g, input logic [31:0] pc, input int h);
        int base;
        base = int'((pc / 4) % 256);
        return (g == 1) ? (base ^ h) : base;
    endfunction

    function automatic bit m_hit(input int g, input logic [31:0] pc);
        int s;
        s = slot(pc);
        return m_valid[g][s] && ((m_pc[g][s] / 256) == (pc / 256));
    endfunction

    function automatic bit m_je(input int g);
        if (rst) return 1'b0;
        return m_hit(g, pc_if) && (m_pht[g][cidx(g, pc_if, m_ghr[g])] >= 2);
    endfunction

    function automatic logic [31:0] m_jdest(input int g);
        return m_je(g) ? m_tgt[g][slot(pc_if)] : 32'd0;
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            bit pj, ph;
            pj = m_je(g);
            ph = m_hit(g, pc_if);
            if (rst) begin
                for (int i = 0; i < 64; i++) m_valid[g][i] = 1'b0;
                for (int i = 0; i < 256; i++) m_pht[g][i] = 2;
                m_ghr[g] = 0;
            end else begin
                if (ex_valid) begin
                    int c;
                    m_valid[g][slot(pc_ex)] = 1'b1;
                    m_pc[g][slot(pc_ex)]    = pc_ex;
                    m_tgt[g][slot(pc_ex)]   = dest;
                    c = cidx(g, pc_ex, int'(hist_ex));
                    if (jmp_res) m_pht[g][c] = (m_pht[g][c] == 3) ? 3 : m_pht[g][c] + 1;
                    else         m_pht[g][c] = (m_pht[g][c] == 0) ? 0 : m_pht[g][c] - 1;
                end
                if (ex_valid && mispred)
                    m_ghr[g] = ((int'(hist_ex) * 2) + int'(jmp_res)) % 256;
                else if (if_valid && ph)
                    m_ghr[g] = ((m_ghr[g] * 2) + int'(pj)) % 256;
            end
        end
    end

    task automatic cmp(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[inst %0d] t=%0t: got %h, expected %h", name, g, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 2; g++) begin
                cmp("je",      g, 32'(je_o[g]),   32'(m_je(g)));
                cmp("jdest",   g, jdest_o[g],     m_jdest(g));
                cmp("hist_if", g, 32'(hist_o[g]), rst ? 32'd0 : 32'(m_ghr[g]));
                cmp("ghr",     g, 32'(ghr_o[g]),  32'(m_ghr[g]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic iv, input logic [31:0] pi, input logic ev, input logic [31:0] pe,
                          input logic [31:0] d, input logic jr, input logic [7:0] he, input logic mp);
        if_valid = iv; pc_if = pi; ex_valid = ev; pc_ex = pe;
        dest = d; jmp_res = jr; hist_ex = he; mispred = mp;
    endtask

    // One resolve cycle with fetch idle on 0x100, then EX goes quiet.
    task automatic resolve(input logic [31:0] pe, input logic [31:0] d, input logic jr,
                           input logic [7:0] he, input logic mp);
        set_in(1'b0, 32'h100, 1'b1, pe, d, jr, he, mp);
        tick();
        set_in(1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0);
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        cmp("rst_je", 0, 32'(je_o[0]), 32'd0);
        cmp("rst_ghr", 1, 32'(ghr_o[1]), 32'd0);

        // Cold fetch misses; history must not move.
        rst = 1'b0;
        tick();
        set_in(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        cmp("cold_je", 0, 32'(je_o[0]), 32'd0);
        cmp("cold_jdest", 0, jdest_o[0], 32'd0);
        tick();
        @(negedge clk);
        cmp("miss_noshift", 1, 32'(ghr_o[1]), 32'd0);

        // First mispredicted taken resolve: counter 10->11, history repaired to 0x01.
        resolve(32'h100, 32'h200, 1'b1, 8'h00, 1'b1);
        if_valid = 1'b1;
        @(negedge clk);
        cmp("train_je", 0, 32'(je_o[0]), 32'd1);
        cmp("train_jdest", 0, jdest_o[0], 32'h200);
        cmp("train_ghr", 0, 32'(ghr_o[0]), 32'h01);
        if_valid = 1'b0;

        // Saturation on the bimodal instance.
        for (int i = 0; i < 4; i++) resolve(32'h100, 32'h200, 1'b1, 8'h00, 1'b0);
        resolve(32'h100, 32'h200, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        cmp("sat_nt1", 0, 32'(je_o[0]), 32'd1);
        resolve(32'h100, 32'h200, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        cmp("sat_nt2", 0, 32'(je_o[0]), 32'd0);
        resolve(32'h100, 32'h200, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        cmp("sat_nt3", 0, 32'(je_o[0]), 32'd0);
        for (int i = 0; i < 5; i++) resolve(32'h100, 32'h200, 1'b0, 8'h00, 1'b0);
        resolve(32'h100, 32'h200, 1'b1, 8'h00, 1'b0);
        @(negedge clk);
        cmp("sat_floor", 0, 32'(je_o[0]), 32'd0);

        // Gshare: same PC, opposite training under two histories.
        for (int i = 0; i < 2; i++) resolve(32'h100, 32'h200, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) resolve(32'h100, 32'h200, 1'b0, 8'h01, 1'b0);
        resolve(32'h304, 32'h400, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        cmp("gs_ghr0", 1, 32'(ghr_o[1]), 32'h00);
        cmp("gs_je_h0", 1, 32'(je_o[1]), 32'd1);
        resolve(32'h304, 32'h400, 1'b1, 8'h00, 1'b1);
        @(negedge clk);
        cmp("gs_ghr1", 1, 32'(ghr_o[1]), 32'h01);
        cmp("gs_je_h1", 1, 32'(je_o[1]), 32'd0);

        // Repair beats a same-cycle IF hit.
        resolve(32'h304, 32'h400, 1'b1, 8'h52, 1'b1);
        @(negedge clk);
        cmp("pre_repair", 1, 32'(ghr_o[1]), 32'hA5);
        set_in(1'b1, 32'h100, 1'b1, 32'h304, 32'h400, 1'b0, 8'h3C, 1'b1);
        tick();
        set_in(1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        cmp("repair", 0, 32'(ghr_o[0]), 32'h78);
        cmp("repair", 1, 32'(ghr_o[1]), 32'h78);

        // Tag mismatch: same BTB slot as 0x100, different upper address.
        pc_if = 32'h100 + (32'd4 << 6);
        @(negedge clk);
        cmp("tag_je", 1, 32'(je_o[1]), 32'd0);
        cmp("tag_jdest", 1, jdest_o[1], 32'd0);

        // Mid-stream reset with concurrent fetch and resolve.
        rst = 1'b1;
        set_in(1'b1, 32'h304, 1'b1, 32'h100, 32'h500, 1'b1, 8'h11, 1'b1);
        @(negedge clk);
        cmp("rst_mid_je", 1, 32'(je_o[1]), 32'd0);
        cmp("rst_mid_hist", 1, 32'(hist_o[1]), 32'd0);
        tick();
        rst = 1'b0;
        set_in(1'b1, 32'h304, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        cmp("post_rst_ghr", 1, 32'(ghr_o[1]), 32'd0);
        cmp("post_rst_je", 1, 32'(je_o[1]), 32'd0);
        cmp("post_rst_jdest", 0, jdest_o[0], 32'd0);

        // Randomised traffic over a small PC set so hits, aliasing and conflicts are common.
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst      = ($urandom_range(0, 299) == 0);
            if_valid = $urandom_range(0, 1);
            pc_if    = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
            ex_valid = $urandom_range(0, 1);
            pc_ex    = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
            dest     = $urandom() & 32'hFFFF_FFFC;
            jmp_res  = $urandom_range(0, 1);
            hist_ex  = 8'($urandom_range(0, 255));
            mispred  = ($urandom_range(0, 9) < 3);
        end
        tick();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
